// File: rtl/vga_timing_core.sv
// 640x480@60 scan counters with registered sync/colour pins; sync and colour lag x/y by one clk.
// enable only gates the counters; the pin stage samples every cycle.
module vga_timing_core (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [5:0] rgb_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       next_frame,
    output logic [7:0] frame_count,
    output logic       hsync,
    output logic       vsync,
    output logic [5:0] rgb_out
);

    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_FRONT      = 10'd16;
    localparam logic [9:0] H_SYNC       = 10'd96;
    localparam logic [9:0] H_LAST       = 10'd799;
    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_FRONT      = 10'd10;
    localparam logic [9:0] V_SYNC       = 10'd2;
    localparam logic [9:0] V_LAST       = 10'd524;

    localparam logic [9:0] H_SYNC_FIRST = H_VISIBLE + H_FRONT;
    localparam logic [9:0] H_SYNC_LAST  = H_VISIBLE + H_FRONT + H_SYNC - 10'd1;
    localparam logic [9:0] V_SYNC_FIRST = V_VISIBLE + V_FRONT;
    localparam logic [9:0] V_SYNC_LAST  = V_VISIBLE + V_FRONT + V_SYNC - 10'd1;

    logic [9:0] h_count;
    logic [9:0] v_count;
    logic       h_last;
    logic       v_last;
    logic       hsync_raw;
    logic       vsync_raw;

    assign x      = h_count;
    assign y      = v_count;
    assign h_last = (h_count == H_LAST);
    assign v_last = (v_count == V_LAST);

    assign active     = (h_count < H_VISIBLE) && (v_count < V_VISIBLE);
    // Gated by enable so a paused scan parked at the frame boundary emits nothing.
    assign next_frame = enable && (h_count == 10'd0) && (v_count == V_VISIBLE);

    assign hsync_raw = !((h_count >= H_SYNC_FIRST) && (h_count <= H_SYNC_LAST));
    assign vsync_raw = !((v_count >= V_SYNC_FIRST) && (v_count <= V_SYNC_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_count <= 10'd0;
            v_count <= 10'd0;
        end else if (enable) begin
            if (h_last) begin
                h_count <= 10'd0;
                v_count <= v_last ? 10'd0 : v_count + 10'd1;
            end else begin
                h_count <= h_count + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count <= 8'd0;
        end else if (next_frame) begin
            frame_count <= frame_count + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            rgb_out <= 6'd0;
        end else begin
            hsync   <= hsync_raw;
            vsync   <= vsync_raw;
            rgb_out <= active ? rgb_in : 6'd0;
        end
    end

endmodule

// File: doc/vga_timing_core.md
VGA_TIMING_CORE -- requirements
Module: vga_timing_core

Interface
REQ-001 SHALL provide: clk  input  1  pixel clock (25.175 MHz nominal, one pixel per cycle).
REQ-002 SHALL provide: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide: enable  input  1  advance scan counters when high; hold when low.
REQ-004 SHALL provide: rgb_in  input  6  pixel colour from pattern generator, sampled for current x/y.
REQ-005 SHALL provide: x  output  10  current horizontal scan position (0..799).
REQ-006 SHALL provide: y  output  10  current vertical scan position (0..524).
REQ-007 SHALL provide: active  output  1  high when x<640 and y<480.
REQ-008 SHALL provide: next_frame  output  1  single-cycle pulse once per frame at start of vertical blanking.
REQ-009 SHALL provide: frame_count  output  8  frames completed since reset, wraps.
REQ-010 SHALL provide: hsync  output  1  registered horizontal sync, active-low.
REQ-011 SHALL provide: vsync  output  1  registered vertical sync, active-low.
REQ-012 SHALL provide: rgb_out  output  6  registered pixel colour to pins, aligned with hsync/vsync.

Function
REQ-013 SHALL implement 640x480@60 timing: H = 640 visible, 16 front porch, 96 sync, 48 back porch (800 total); V = 480 visible, 10 front porch, 2 sync, 33 back porch (525 total).
REQ-014 SHALL hold h_count and v_count in registers; x and y SHALL be driven directly from them (no combinational offset).
REQ-015 When enable=1, h_count SHALL increment by 1 each clk; at h_count=799 it SHALL wrap to 0 on the next edge.
REQ-016 v_count SHALL increment only on the edge where h_count wraps 799->0; at v_count=524 with h_count=799 both SHALL wrap to 0 on the same edge.
REQ-017 When enable=0, h_count, v_count and frame_count SHALL hold; next_frame SHALL be 0.
REQ-018 active SHALL be decoded combinationally from the counter registers: (h_count<640) and (v_count<480).
REQ-019 next_frame SHALL equal enable AND (h_count=0) AND (v_count=480); exactly one cycle high per frame while enable stays high.
REQ-020 frame_count SHALL increment by 1 on each clk edge where next_frame=1; 255 SHALL wrap to 0.
REQ-021 Raw sync: hsync_raw low iff 656<=h_count<=751; vsync_raw low iff 490<=v_count<=491.
REQ-022 Output stage SHALL register every cycle regardless of enable: hsync<=hsync_raw, vsync<=vsync_raw, rgb_out<=(active ? rgb_in : 6'b0).
REQ-023 Latency: rgb_out, hsync and vsync SHALL reflect the x/y presented one clk earlier; rgb_in SHALL be treated as combinational from x/y.
REQ-024 rgb_out SHALL be 0 for every pixel registered while active=0, independent of rgb_in.
REQ-025 Counter comparisons SHALL use exact equality/range on 10-bit values; no counter SHALL ever hold h_count>799 or v_count>524.

Reset
REQ-026 On rst assertion, asynchronously: h_count=0, v_count=0, frame_count=0, hsync=1, vsync=1, rgb_out=0.
REQ-027 After reset release, the first enabled edge SHALL move h_count 0->1; x=0,y=0,active=1 SHALL be visible during reset.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; no next_frame pulse and no frame_count change SHALL result from the abandoned frame.

Verification
REQ-029 Free-run from reset, enable=1, 2 frames -> hsync low for exactly 96 cycles per line starting at h_count=656; line period 800; frame period 420000 cycles.
REQ-030 Vsync check -> vsync low for exactly 1600 cycles (lines 490-491) per frame; next_frame high exactly once per frame at (h=0,v=480); frame_count 0->1->2.
REQ-031 rgb_in forced 6'b111111 -> rgb_out=6'b111111 one cycle after each (x<640,y<480), 0 one cycle after (x=640,y=0) and throughout lines 480..524.
REQ-032 Wrap boundary: run to (h=799,v=524) -> next edge gives x=0,y=0; frame_count at 255 plus one next_frame -> 0.
REQ-033 enable deasserted at (h=0,v=480) for 10 cycles -> x,y,frame_count hold, next_frame=0 throughout; on re-enable next_frame pulses once, frame_count +1.
REQ-034 rst asserted at (h=300,v=200) for 3 cycles -> immediate hsync=1, vsync=1, rgb_out=0, x=y=0, frame_count=0; normal timing resumes after release.
